// File: rtl/tilemap_pkg.sv
// Shared constants, opcodes, FSM encoding and latched-command layout for the tile-map writer.
package tilemap_pkg;

    localparam int MAP_W_DEFAULT = 120;
    localparam int MAP_H_DEFAULT = 68;
    localparam int COORD_W       = 7;
    localparam int TILE_W        = 6;
    localparam int ADDR_W        = 13;

    localparam logic [TILE_W-1:0] TILE_EMPTY_DEFAULT = 6'b111111;

    typedef enum logic [1:0] {
        OP_FILL  = 2'b00,
        OP_CLEAR = 2'b01,
        OP_PLOT  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // w/h carry one extra bit so a full-map CLEAR fits the same datapath.
    typedef struct packed {
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] y0;
        logic [COORD_W:0]   w;
        logic [COORD_W:0]   h;
        logic [TILE_W-1:0]  tile;
    } rect_t;

    // Exclusive end coordinate, summed one bit wider than the coordinate so it never wraps.
    function automatic logic [COORD_W:0] clip_end(input logic [COORD_W-1:0] start,
                                                  input logic [COORD_W:0] len,
                                                  input int lim);
        logic [COORD_W:0] sum;
        sum = {1'b0, start} + len;
        return (int'(sum) > lim) ? (COORD_W+1)'(lim) : sum;
    endfunction

endpackage

// File: rtl/tilemap_writer_if.sv
// Command handshake and generator-RAM write bus of the tile-map writer.
interface tilemap_writer_if;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [1:0]  i_cmd_op;
    logic [6:0]  i_cmd_x0;
    logic [6:0]  i_cmd_y0;
    logic [6:0]  i_cmd_w;
    logic [6:0]  i_cmd_h;
    logic [5:0]  i_cmd_tile;
    logic        o_wr_en;
    logic [12:0] o_wr_address;
    logic [5:0]  o_wr_data;
    logic        o_busy;
    logic        o_done;

    modport master (
        output i_cmd_valid, i_cmd_op, i_cmd_x0, i_cmd_y0, i_cmd_w, i_cmd_h, i_cmd_tile,
        input  o_cmd_ready, o_wr_en, o_wr_address, o_wr_data, o_busy, o_done
    );

    modport slave (
        input  i_cmd_valid, i_cmd_op, i_cmd_x0, i_cmd_y0, i_cmd_w, i_cmd_h, i_cmd_tile,
        output o_cmd_ready, o_wr_en, o_wr_address, o_wr_data, o_busy, o_done
    );
endinterface

// File: rtl/tilemap_rect_walker.sv
// Clipped rectangle scanner: loads bounds once, then steps row-major producing y*MAP_W+x.
module tilemap_rect_walker
    import tilemap_pkg::*;
#(
    parameter int MAP_W = MAP_W_DEFAULT,
    parameter int MAP_H = MAP_H_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [COORD_W-1:0] i_x0,
    input  logic [COORD_W-1:0] i_y0,
    input  logic [COORD_W:0]   i_w,
    input  logic [COORD_W:0]   i_h,
    output logic               o_empty,
    output logic               o_last,
    output logic [ADDR_W-1:0]  o_addr
);
    localparam logic [ADDR_W-1:0]  ROW_STEP = ADDR_W'(MAP_W);
    localparam logic [ADDR_W-1:0]  ADDR_ONE = ADDR_W'(1);
    localparam logic [COORD_W-1:0] C_ONE    = COORD_W'(1);
    localparam logic [COORD_W:0]   E_ONE    = (COORD_W+1)'(1);

    logic [COORD_W:0]   x_end_c, y_end_c, xe_q, ye_q, x_nxt, y_nxt;
    logic [COORD_W-1:0] x_q, y_q, xs_q;
    logic [ADDR_W-1:0]  row_base_c, row_q, addr_q;
    logic               row_end;

    assign x_end_c    = clip_end(i_x0, i_w, MAP_W);
    assign y_end_c    = clip_end(i_y0, i_h, MAP_H);
    assign o_empty    = (x_end_c <= {1'b0, i_x0}) || (y_end_c <= {1'b0, i_y0});
    // The only multiply: done once at load; rows then advance by an adder.
    assign row_base_c = ADDR_W'(i_y0) * ROW_STEP;

    assign x_nxt   = {1'b0, x_q} + E_ONE;
    assign y_nxt   = {1'b0, y_q} + E_ONE;
    assign row_end = (x_nxt >= xe_q);
    assign o_last  = row_end && (y_nxt >= ye_q);
    assign o_addr  = addr_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            x_q    <= '0;
            y_q    <= '0;
            xs_q   <= '0;
            xe_q   <= '0;
            ye_q   <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else if (i_load) begin
            x_q    <= i_x0;
            y_q    <= i_y0;
            xs_q   <= i_x0;
            xe_q   <= x_end_c;
            ye_q   <= y_end_c;
            row_q  <= row_base_c;
            addr_q <= row_base_c + ADDR_W'(i_x0);
        end else if (i_step) begin
            if (!row_end) begin
                x_q    <= x_q + C_ONE;
                addr_q <= addr_q + ADDR_ONE;
            end else begin
                x_q    <= xs_q;
                y_q    <= y_q + C_ONE;
                row_q  <= row_q + ROW_STEP;
                addr_q <= row_q + ROW_STEP + ADDR_W'(xs_q);
            end
        end
    end

endmodule

// File: rtl/tilemap_writer.sv
// Tile-map writer: accepts fill/clear/plot commands and streams generator-RAM writes.
// Optional TILEMAP_WRITER_VBLANK_GATE_EN stalls the write scan outside vertical blanking.
module tilemap_writer
    import tilemap_pkg::*;
#(
    parameter int                MAP_W      = MAP_W_DEFAULT,
    parameter int                MAP_H      = MAP_H_DEFAULT,
    parameter logic [TILE_W-1:0] TILE_EMPTY = TILE_EMPTY_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_vblank,
    tilemap_writer_if.slave  bus
);
    state_e state_q, state_d;
    rect_t  cmd_q, cmd_d;
    logic   gate, empty, last, step, accept, load;
    logic   ready, busy, done, wr_en;

`ifdef TILEMAP_WRITER_VBLANK_GATE_EN
    assign gate = i_vblank;
`else
    logic unused_vblank;
    assign unused_vblank = i_vblank;
    assign gate = 1'b1;
`endif

    // Normalise every opcode into a rectangle so one scanner serves them all.
    always_comb begin
        cmd_d.x0   = bus.i_cmd_x0;
        cmd_d.y0   = bus.i_cmd_y0;
        cmd_d.w    = {1'b0, bus.i_cmd_w};
        cmd_d.h    = {1'b0, bus.i_cmd_h};
        cmd_d.tile = bus.i_cmd_tile;
        case (op_e'(bus.i_cmd_op))
            OP_CLEAR: begin
                cmd_d.x0   = '0;
                cmd_d.y0   = '0;
                cmd_d.w    = (COORD_W+1)'(MAP_W);
                cmd_d.h    = (COORD_W+1)'(MAP_H);
                cmd_d.tile = TILE_EMPTY;
            end
            OP_PLOT: begin
                cmd_d.w = (COORD_W+1)'(1);
                cmd_d.h = (COORD_W+1)'(1);
            end
            OP_RSVD: begin
                cmd_d.w = '0;
                cmd_d.h = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) cmd_q <= cmd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
                if (bus.i_cmd_valid) state_d = S_SETUP;
            end
            S_SETUP: state_d = empty ? S_DONE : S_WRITE;
            S_WRITE: begin
                wr_en = gate;
                if (gate && last) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign accept = ready && bus.i_cmd_valid;
    assign load   = (state_q == S_SETUP);
    assign step   = wr_en;

    tilemap_rect_walker #(
        .MAP_W (MAP_W),
        .MAP_H (MAP_H)
    ) u_walker (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (load),
        .i_step  (step),
        .i_x0    (cmd_q.x0),
        .i_y0    (cmd_q.y0),
        .i_w     (cmd_q.w),
        .i_h     (cmd_q.h),
        .o_empty (empty),
        .o_last  (last),
        .o_addr  (bus.o_wr_address)
    );

    assign bus.o_cmd_ready = ready;
    assign bus.o_busy      = busy;
    assign bus.o_done      = done;
    assign bus.o_wr_en     = wr_en;
    assign bus.o_wr_data   = cmd_q.tile;

endmodule

// File: doc/tilemap_writer.md
TILEMAP_WRITER -- requirements
Module: tilemap_writer

Interface
REQ-001 Parameter MAP_W, default 120, tile-map width in 4x4-pixel tiles.
REQ-002 Parameter MAP_H, default 68, tile-map height in tiles.
REQ-003 Parameter TILE_EMPTY, default 6'b111111, transparent tile index.
REQ-004 i_clk  in  1  single system clock; all logic on its rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 i_cmd_valid  in  1  command offered.
REQ-007 o_cmd_ready  out  1  command accepted when valid&ready.
REQ-008 i_cmd_op  in  2  00 FILL_RECT, 01 CLEAR, 10 PLOT, 11 reserved.
REQ-009 i_cmd_x0, i_cmd_y0  in  7 each  top-left tile coordinate.
REQ-010 i_cmd_w, i_cmd_h  in  7 each  rectangle size in tiles.
REQ-011 i_cmd_tile  in  6  tile index to write.
REQ-012 i_vblank  in  1  high while the display is in vertical blanking.
REQ-013 o_wr_en  out  1  generator-RAM write strobe, one word per cycle.
REQ-014 o_wr_address  out  13  generator-RAM address = y*MAP_W + x.
REQ-015 o_wr_data  out  6  tile index written.
REQ-016 o_busy  out  1  high in every state except IDLE.
REQ-017 o_done  out  1  one-cycle pulse at command completion.

Function
REQ-018 States: IDLE, SETUP, WRITE, DONE; o_cmd_ready SHALL be high only in IDLE.
REQ-019 Handshake at edge k: command fields latched, IDLE->SETUP; SETUP computes clipped bounds and row base y0*MAP_W and moves to WRITE; first o_wr_en SHALL be high in cycle k+2.
REQ-020 WRITE SHALL scan row-major, x fastest; row base SHALL advance by MAP_W per row (adder, no multiplier in WRITE).
REQ-021 Clipping: columns x>=MAP_W and rows y>=MAP_H SHALL be skipped; x0>=MAP_W, y0>=MAP_H, w=0 or h=0 SHALL produce zero writes and go SETUP->DONE.
REQ-022 Sums x0+w, y0+h SHALL be computed 8 bits wide; no wrap to column/row 0.
REQ-023 PLOT SHALL behave as FILL_RECT with w=h=1.
REQ-024 CLEAR SHALL write TILE_EMPTY to addresses 0..MAP_W*MAP_H-1 ascending, ignoring coordinate and tile fields.
REQ-025 Reserved op SHALL be accepted, produce zero writes, and pulse o_done.
REQ-026 After the last write, DONE SHALL last exactly one cycle with o_done=1, then IDLE (ready high the following cycle).
REQ-027 o_wr_address and o_wr_data SHALL be registered and valid only when o_wr_en=1.
REQ-028 i_cmd_valid while busy SHALL be ignored; no queuing.

Reset
REQ-029 i_rst=1 at any edge SHALL force IDLE; next cycle o_wr_en=0, o_done=0, o_busy=0, o_cmd_ready=1, o_wr_address=0, o_wr_data=0.
REQ-030 Reset mid-command SHALL abort it with no further writes and no o_done pulse.
REQ-031 Reset SHALL take priority over a simultaneous handshake.

Configuration
REQ-032 Macro TILEMAP_WRITER_VBLANK_GATE_EN: when defined, WRITE SHALL hold position with o_wr_en=0 while i_vblank=0 and resume at the same tile when i_vblank=1; when undefined, i_vblank SHALL be ignored and writes SHALL be back-to-back.

Structure
REQ-033 Package tilemap_pkg SHALL hold MAP_W/MAP_H defaults, TILE_EMPTY, opcode constants and the state encoding.
REQ-034 One sub-module, tilemap_rect_walker (clipped x/y/address scanner with step and last outputs), SHALL be instantiated; the top holds handshake and state control.

Verification
REQ-035 FILL_RECT x0=0,y0=0,w=2,h=2,tile=5 at edge k -> writes addr 0,1,120,121 data 5 in cycles k+2..k+5; o_done k+6; ready k+7.
REQ-036 FILL_RECT x0=118,y0=66,w=4,h=4,tile=9 -> exactly 4 writes: 8038,8039,8158,8159.
REQ-037 CLEAR -> 8160 consecutive writes, addr 0..8159, data 63, then one o_done pulse.
REQ-038 FILL_RECT w=0 (and x0=120) -> zero writes, o_done in cycle k+2.
REQ-039 i_rst asserted in 3rd write cycle of a 10x10 fill -> o_wr_en low next cycle, no o_done, ready high.
REQ-040 With TILEMAP_WRITER_VBLANK_GATE_EN, PLOT x0=3,y0=1 while i_vblank=0 for 20 cycles -> no write until i_vblank rises; then single write addr 123.
